// File: rtl/lbc_wbctl_if.sv
// Core/bus-side signal bundle for the LBC store write-buffer controller.
// The master modport is the core and bus-queue side; the slave modport is the controller.
interface lbc_wbctl_if #(
  parameter int LBC_WRITES = 4,
  parameter int CW         = 3
);
  logic                  CBUS_DWR;
  logic                  CBUS_DRD;
  logic                  CBUS_DSYNC;
  logic [LBC_WRITES-1:0] LD_FCTLHIT;
  logic                  LL_WACK;
  logic [LBC_WRITES-1:0] LC_FCTLLOAD;
  logic                  LC_FCTLDOSHIFT;
  logic                  LC_WVALID;
  logic                  LC_WBFULL;
  logic                  LC_WBEMPTY;
  logic                  LC_RDHOLD;
  logic [CW-1:0]         LC_WBCOUNT;

  modport master (
    output CBUS_DWR, CBUS_DRD, CBUS_DSYNC, LD_FCTLHIT, LL_WACK,
    input  LC_FCTLLOAD, LC_FCTLDOSHIFT, LC_WVALID, LC_WBFULL, LC_WBEMPTY,
           LC_RDHOLD, LC_WBCOUNT
  );

  modport slave (
    input  CBUS_DWR, CBUS_DRD, CBUS_DSYNC, LD_FCTLHIT, LL_WACK,
    output LC_FCTLLOAD, LC_FCTLDOSHIFT, LC_WVALID, LC_WBFULL, LC_WBEMPTY,
           LC_RDHOLD, LC_WBCOUNT
  );
endinterface

// File: rtl/lbc_wbctl.sv
// LBC store write-buffer control: occupancy tracking, slot load enables, head retire,
// and read-after-write / SYNC drain hold.
module lbc_wbctl #(
  parameter int LBC_WRITES = 4,
  parameter int CW         = 3
) (
  input logic         SYSCLK,
  input logic         RESET_D1_R_N,
  lbc_wbctl_if.slave  bus
);

  typedef enum logic {S_IDLE, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         drain_cnt_q, drain_cnt_d;

  logic [LBC_WRITES-1:0] v;
  logic [LBC_WRITES-1:0] mhit;
  logic [LBC_WRITES-1:0] load;
  logic [CW-1:0]         load_idx;
  logic [CW-1:0]         hi;
  logic                  full, empty, ret, acc, rdhold;

  // Datapath: valid thermometer, accept/retire and the one-hot load slot.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    v     = '0;
    mhit  = '0;
    load  = '0;
    hi    = '0;
    full  = (count_q == CW'(LBC_WRITES));
    empty = (count_q == '0);
    for (int i = 0; i < LBC_WRITES; i++) begin
      v[i] = (CW'(i) < count_q);
    end
    ret      = bus.LL_WACK & v[0];
    acc      = bus.CBUS_DWR & ~full;
    load_idx = count_q - CW'(ret);
    for (int i = 0; i < LBC_WRITES; i++) begin
      load[i] = acc && (load_idx == CW'(i));
    end
    count_d = count_q + CW'(acc) - CW'(ret);
    mhit    = bus.LD_FCTLHIT & v;
    // Ascending scan: the last hit seen is the youngest matching entry.
    for (int i = 0; i < LBC_WRITES; i++) begin
      if (mhit[i]) hi = CW'(i);
    end
  end

  // Hold FSM: a read hit or SYNC latches how many head retires must occur before release.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    rdhold      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.CBUS_DRD && (mhit != '0)) begin
          rdhold      = 1'b1;
          drain_cnt_d = hi + CW'(1) - CW'(ret);
          if (drain_cnt_d != '0) state_d = S_DRAIN;
        end else if (bus.CBUS_DSYNC && !empty) begin
          rdhold      = 1'b1;
          drain_cnt_d = count_q - CW'(ret);
          if (drain_cnt_d != '0) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rdhold = 1'b1;
        if (ret) begin
          drain_cnt_d = drain_cnt_q - CW'(1);
          if (drain_cnt_q == CW'(1)) state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        drain_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge SYSCLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign bus.LC_FCTLLOAD    = load;
  assign bus.LC_FCTLDOSHIFT = ret;
  assign bus.LC_WVALID      = v[0];
  assign bus.LC_WBFULL      = full;
  assign bus.LC_WBEMPTY     = empty;
  assign bus.LC_RDHOLD      = rdhold;
  assign bus.LC_WBCOUNT     = count_q;

`ifndef SYNTHESIS
  // Counter invariants; any hit here is a design error, not a legal operating condition.
  always @(posedge SYSCLK) begin
    if (RESET_D1_R_N) begin
      if (count_q > CW'(LBC_WRITES))
        $display("lbc_wbctl: occupancy overflow count=%0d", count_q);
      if (state_q == S_DRAIN && drain_cnt_q == '0)
        $display("lbc_wbctl: drain counter underflow in DRAIN");
      if (drain_cnt_q > count_q)
        $display("lbc_wbctl: drain_cnt=%0d exceeds count=%0d", drain_cnt_q, count_q);
    end
  end
`endif

endmodule

// File: doc/lbc_wbctl.md
Name: lbc_wbctl

Overview:
- Control block for the LBC store write buffer, single SYSCLK domain; feeds the LBC data path.
- Tracks occupancy of the shift-FIFO write buffer and generates the one-hot per-slot load enables and the head-retire shift.
- Requests bus issue of the head entry and handles read-after-write hazards: a core data read that hits a buffered write is held until the buffer drains through the youngest matching entry.
- Same drain mechanism serves SYNC.

Parameters:
LBC_WRITES, 4, number of write buffer entries (>=2); slot 0 is the head (oldest)
CW, 3, width of occupancy/drain counters; must hold 0..LBC_WRITES

Ports:
SYSCLK  in  1  system clock; all state on rising edge
RESET_D1_R_N  in  1  asynchronous, active-low reset
CBUS_DWR  in  1  core store valid this cycle; accepted iff LC_WBFULL=0
CBUS_DRD  in  1  core data read request; held by core while LC_RDHOLD=1
CBUS_DSYNC  in  1  one-cycle sync request: drain all currently buffered writes
LD_FCTLHIT  in  LBC_WRITES  per-slot address/uncached match against pending read
LL_WACK  in  1  bus accepted head write this cycle (head retires)
LC_FCTLLOAD  out  LBC_WRITES  one-hot slot load enable (combinational)
LC_FCTLDOSHIFT  out  1  shift buffer toward slot 0 (combinational)
LC_WVALID  out  1  head entry valid; write request to queue arbiter
LC_WBFULL  out  1  buffer full; core must stall stores
LC_WBEMPTY  out  1  buffer empty
LC_RDHOLD  out  1  pending read or sync blocked until drain completes
LC_WBCOUNT  out  CW  current occupancy

Behaviour:
- Reset (async, RESET_D1_R_N=0): count=0, drain_cnt=0, state=IDLE. Outputs: LC_FCTLLOAD=0, LC_FCTLDOSHIFT=0, LC_WVALID=0, LC_WBFULL=0, LC_WBEMPTY=1, LC_RDHOLD=0, LC_WBCOUNT=0. Reset mid-drain discards all entries and the hold.
- Valid vector v[i] = (i < count), thermometer-coded.
- Derived signals:
  - LC_WBFULL = (count == LBC_WRITES); LC_WBEMPTY = (count == 0).
  - LC_WVALID = v[0].
  - ret = LL_WACK & v[0]; LC_FCTLDOSHIFT = ret. LL_WACK while empty is ignored: no shift, no count change.
  - acc = CBUS_DWR & ~LC_WBFULL. No accept-on-full even if ret is true in the same cycle.
- Load slot: when acc, LC_FCTLLOAD has exactly bit (count - ret) set, otherwise all zero. A write and a retire in the same cycle load slot count-1.
- Count update: count_next = count + acc - ret. Latency: a store accepted in cycle N is visible in LC_WBCOUNT in cycle N+1. A store accepted into an empty buffer raises LC_WVALID in cycle N+1.
- Hazard match: mhit = LD_FCTLHIT & v. hi = index of the highest set bit of mhit.
- State IDLE:
  - If CBUS_DRD and mhit != 0:
    - LC_RDHOLD=1 combinationally in the same cycle.
    - drain_cnt_next = hi + 1 - ret.
    - If drain_cnt_next == 0, stay IDLE; otherwise go to DRAIN.
  - Else if CBUS_DSYNC and count != 0:
    - LC_RDHOLD=1.
    - drain_cnt_next = count - ret.
    - Go to DRAIN if drain_cnt_next != 0.
  - A read hit has priority over a sync in the same cycle. In that case the sync is lost; the core must reissue it.
  - Otherwise LC_RDHOLD=0.
- State DRAIN:
  - LC_RDHOLD=1; LD_FCTLHIT is not re-evaluated.
  - On each ret, drain_cnt decrements.
  - When drain_cnt==1 and ret: return to IDLE next cycle, and LC_RDHOLD falls in that next cycle.
  - New stores are still accepted during DRAIN. They enqueue behind the drain point and do not extend the drain.
- Count and drain_cnt never underflow or overflow. Any violation is a design error and must fire a simulation-only $display.

Test Plan:
- Reset, then 4 consecutive CBUS_DWR, no LL_WACK: LC_FCTLLOAD = 0001, 0010, 0100, 1000. LC_WBFULL=1 in cycle 5 and LC_WBCOUNT=4.
- Full buffer, CBUS_DWR=1 and LL_WACK=1 in the same cycle: LC_FCTLDOSHIFT=1, LC_FCTLLOAD=0000, count goes to 3. Next cycle's CBUS_DWR loads slot 3 (1000).
- count=2, CBUS_DWR=1 and LL_WACK=1: LC_FCTLLOAD=0010 and count stays 2.
- count=3, CBUS_DRD with LD_FCTLHIT=0110: LC_RDHOLD=1 immediately and drain_cnt=3. After the 3rd LL_WACK, LC_RDHOLD=0 the following cycle.
- count=2, CBUS_DRD with LD_FCTLHIT=0100 (slot not valid): LC_RDHOLD=0, no drain.
- count=1, CBUS_DRD with LD_FCTLHIT=0001 and LL_WACK=1 in the same cycle: LC_RDHOLD=1 this cycle only, state stays IDLE, count goes to 0. Then CBUS_DSYNC with count=0 gives LC_RDHOLD=0.
